// File: rtl/reg_file_sync.sv
// Parametrised register file: one synchronous write port, two combinational
// read ports, optional hardwired-zero entry 0, optional write-to-read bypass,
// and a sequencer that clears one entry per cycle after reset or on request.
module reg_file_sync #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_drop
);

  // Array index width; addresses are truncated to it only after range checks.
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // DEPTH may equal 2**ADDR_W, so compare addresses one bit wider.
  localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                wr_drop_q, wr_drop_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                busy_c;
  logic                wr_ok_c;
  logic                mem_we_c;
  logic [IDX_W-1:0]    mem_widx_c;
  logic [DATA_W-1:0]   mem_wdata_c;
  logic [DATA_W-1:0]   rdata1_c;
  logic [DATA_W-1:0]   rdata2_c;

  // An address is live when it maps to a real, writable/readable entry.
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_V) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Clear in progress (reset cycle included): writes dropped, reads masked.
  assign busy_c  = rst | (state_q == CLEAR);
  assign wr_ok_c = we & ~busy_c & addr_live(waddr);

  // Next-state and array write-port selection.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wr_drop_d   = we & busy_c;
    mem_we_c    = 1'b0;
    mem_widx_c  = IDX_W'(waddr);
    mem_wdata_c = wdata;
    case (state_q)
      IDLE: begin
        mem_we_c = wr_ok_c;
        if (clr_req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        mem_we_c    = 1'b1;
        mem_widx_c  = IDX_W'(idx_q);
        mem_wdata_c = '0;
        idx_d       = idx_q + ADDR_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end
      end
      default: state_d = CLEAR;
    endcase
    if (rst) begin
      mem_we_c = 1'b0;
    end
  end

  // Control state with synchronous reset into a fresh clear pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      idx_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Storage array; no reset so it can map onto a plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[mem_widx_c] <= mem_wdata_c;
    end
  end

  // Read port 1 with masking and optional same-cycle forwarding.
  always_comb begin
    rdata1_c = mem_q[IDX_W'(raddr1)];
    if (busy_c || !addr_live(raddr1)) begin
      rdata1_c = '0;
    end else if ((BYPASS != 0) && wr_ok_c && (waddr == raddr1)) begin
      rdata1_c = wdata;
    end
  end

  // Read port 2 with masking and optional same-cycle forwarding.
  always_comb begin
    rdata2_c = mem_q[IDX_W'(raddr2)];
    if (busy_c || !addr_live(raddr2)) begin
      rdata2_c = '0;
    end else if ((BYPASS != 0) && wr_ok_c && (waddr == raddr2)) begin
      rdata2_c = wdata;
    end
  end

  assign rdata1  = rdata1_c;
  assign rdata2  = rdata2_c;
  assign busy    = busy_c;
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_reg_file_sync.sv
// Bench for reg_file_sync: three configurations share one stimulus stream
// (default, no bypass, DEPTH=16) and are checked against a behavioural model.
module tb_reg_file_sync;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic        clr_req = 1'b0;
  logic [4:0]  waddr = '0;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;
  logic [31:0] wdata = '0;

  logic [31:0] r1 [3];
  logic [31:0] r2 [3];
  logic        bz [3];
  logic        dr [3];

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  reg_file_sync #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .rdata1(r1[0]), .raddr2(raddr2), .rdata2(r2[0]),
    .clr_req(clr_req), .busy(bz[0]), .wr_drop(dr[0]));

  reg_file_sync #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .rdata1(r1[1]), .raddr2(raddr2), .rdata2(r2[1]),
    .clr_req(clr_req), .busy(bz[1]), .wr_drop(dr[1]));

  reg_file_sync #(.DATA_W(32), .DEPTH(16), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_c (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .rdata1(r1[2]), .raddr2(raddr2), .rdata2(r2[2]),
    .clr_req(clr_req), .busy(bz[2]), .wr_drop(dr[2]));

  // Behavioural model: contents, remaining clear cycles, pending drop flag.
  int unsigned dep [3] = '{32, 32, 16};
  bit          byp [3] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] mm  [3][32];
  int          clr_left [3] = '{0, 0, 0};
  bit          mdrop [3] = '{1'b0, 1'b0, 1'b0};

  initial begin
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 32; i++) mm[k][i] = '0;
  end

  function automatic bit m_busy(int k);
    return rst || (clr_left[k] > 0);
  endfunction

  function automatic bit m_wok(int k);
    return we && !m_busy(k) && (waddr < dep[k]) && (waddr != 0);
  endfunction

  function automatic logic [31:0] m_rd(int k, logic [4:0] a);
    if (m_busy(k)) return 32'h0;
    if (a >= dep[k] || a == 0) return 32'h0;
    if (byp[k] && m_wok(k) && waddr == a) return wdata;
    return mm[k][a];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        clr_left[k] = dep[k];
        mdrop[k] = 1'b0;
      end else if (clr_left[k] > 0) begin
        mdrop[k] = we;
        clr_left[k] = clr_left[k] - 1;
        if (clr_left[k] == 0)
          for (int i = 0; i < 32; i++) mm[k][i] = '0;
      end else begin
        mdrop[k] = 1'b0;
        if (m_wok(k)) mm[k][waddr] = wdata;
        if (clr_req) clr_left[k] = dep[k];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output of every instance against the model.
  always @(negedge clk) begin
    if (checking) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("dut%0d busy", k), 32'(bz[k]), 32'(m_busy(k)));
        chk($sformatf("dut%0d wr_drop", k), 32'(dr[k]), 32'(mdrop[k]));
        chk($sformatf("dut%0d rdata1", k), r1[k], m_rd(k, raddr1));
        chk($sformatf("dut%0d rdata2", k), r2[k], m_rd(k, raddr2));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    tick();
    we = 1'b1;
    clr_req = 1'b0;
    waddr = a;
    wdata = d;
  endtask

  task automatic idle();
    tick();
    we = 1'b0;
    clr_req = 1'b0;
  endtask

  // Count busy cycles from the current one until both 32- and 16-deep
  // instances are idle; releases rst after the first cycle, pokes clr_req
  // once at iteration pk.
  task automatic count_busy(input int pk, output int na, output int nc);
    na = 0;
    nc = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bz[0]) na++;
      if (bz[2]) nc++;
      if (!bz[0] && !bz[2]) break;
      tick();
      rst = 1'b0;
      we = 1'b0;
      clr_req = (c == pk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int na;
    int nc;

    // Reset and initial clear timing.
    tick();
    checking = 1'b1;
    count_busy(-1, na, nc);
    chk("busy cycles depth32", 32'(na), 32'd33);
    chk("busy cycles depth16", 32'(nc), 32'd17);
    for (int a = 0; a < 32; a++) begin
      tick();
      raddr1 = 5'(a);
      raddr2 = 5'(31 - a);
      @(negedge clk);
      chk("post-reset read", r1[0], 32'h0);
    end

    // Write/read with and without bypass.
    wr(5'd5, 32'hDEADBEEF);
    raddr1 = 5'd5;
    raddr2 = 5'd5;
    @(negedge clk);
    chk("bypass same cycle", r1[0], 32'hDEADBEEF);
    chk("no bypass same cycle", r1[1], 32'h0);
    idle();
    @(negedge clk);
    chk("no bypass next cycle", r1[1], 32'hDEADBEEF);
    chk("bypass next cycle", r2[0], 32'hDEADBEEF);

    // Hardwired zero entry.
    wr(5'd0, 32'h1234);
    raddr1 = 5'd0;
    raddr2 = 5'd0;
    @(negedge clk);
    chk("zero reg port1 same", r1[0], 32'h0);
    chk("zero reg port2 same", r2[0], 32'h0);
    idle();
    @(negedge clk);
    chk("zero reg port1 next", r1[0], 32'h0);
    chk("zero reg port2 next", r2[1], 32'h0);
    chk("zero reg no drop", 32'(dr[0]), 32'h0);

    // Write in the clr_req cycle is kept until cleared; write during clear drops.
    wr(5'd7, 32'h77);
    tick();
    we = 1'b1;
    waddr = 5'd9;
    wdata = 32'h99;
    clr_req = 1'b1;
    raddr1 = 5'd9;
    @(negedge clk);
    chk("write with clr_req bypass", r1[0], 32'h99);
    tick();
    clr_req = 1'b0;
    we = 1'b1;
    waddr = 5'd7;
    wdata = 32'hA5A5A5A5;
    @(negedge clk);
    chk("busy during clear", 32'(bz[0]), 32'h1);
    tick();
    we = 1'b0;
    @(negedge clk);
    chk("wr_drop after busy write", 32'(dr[0]), 32'h1);
    count_busy(-1, na, nc);
    tick();
    raddr1 = 5'd7;
    raddr2 = 5'd9;
    @(negedge clk);
    chk("entry 7 cleared", r1[0], 32'h0);
    chk("entry 9 cleared", r2[0], 32'h0);

    // Fill, clr_req, reset at clear cycle 10, ignored clr_req afterwards.
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
    idle();
    raddr1 = 5'd31;
    raddr2 = 5'd17;
    @(negedge clk);
    chk("filled entry 31", r1[0], 32'd31);
    chk("filled entry 17", r2[0], 32'd17);
    chk("depth16 entry 17 out of range", r2[2], 32'h0);
    tick();
    clr_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      clr_req = 1'b0;
    end
    rst = 1'b1;
    count_busy(5, na, nc);
    chk("busy after mid-clear rst depth32", 32'(na), 32'd33);
    chk("busy after mid-clear rst depth16", 32'(nc), 32'd17);
    for (int a = 0; a < 32; a++) begin
      tick();
      raddr1 = 5'(a);
      raddr2 = 5'(a);
      @(negedge clk);
      chk("post-restart read", r1[0], 32'h0);
    end

    // Out-of-range write on the 16-deep instance.
    for (int i = 1; i < 16; i++) wr(5'(i), 32'(i * 3));
    wr(5'd20, 32'hFF);
    raddr1 = 5'd20;
    raddr2 = 5'd4;
    @(negedge clk);
    chk("oob read same cycle", r1[2], 32'h0);
    chk("in-range bypass addr 20", r1[0], 32'hFF);
    idle();
    @(negedge clk);
    chk("oob read next cycle", r1[2], 32'h0);
    chk("oob no wr_drop", 32'(dr[2]), 32'h0);
    chk("entry 4 intact", r2[2], 32'd12);
    for (int i = 0; i < 16; i++) begin
      tick();
      raddr1 = 5'(i);
      @(negedge clk);
      chk("depth16 entry", r1[2], (i == 0) ? 32'h0 : 32'(i * 3));
    end

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_sync.md
Name: reg_file_sync

Overview:
- Parametrised successor to the combinational-read register file.
- Synchronous write port, two combinational read ports, optional hardwired-zero entry 0, optional write-to-read bypass.
- Built-in clear sequencer zeroes the array one entry per cycle after reset or on request. The array can therefore map to RAM that cannot be reset in a single cycle.
- Sits in the datapath between decode (read addresses) and writeback (write port).

Parameters:
- DATA_W, 32, width of each register entry.
- DEPTH, 32, number of entries (1..2**ADDR_W).
- ADDR_W, 5, width of all address ports.
- ZERO_REG, 1, when 1 entry 0 always reads 0 and writes to it are discarded.
- BYPASS, 1, when 1 a same-cycle write to a read address is forwarded to that read port.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- we  input  1  write enable.
- waddr  input  ADDR_W  write address.
- wdata  input  DATA_W  write data.
- raddr1  input  ADDR_W  read port 1 address.
- rdata1  output  DATA_W  read port 1 data (combinational).
- raddr2  input  ADDR_W  read port 2 address.
- rdata2  output  DATA_W  read port 2 data (combinational).
- clr_req  input  1  single-cycle request to re-zero the whole array.
- busy  output  1  clear in progress; writes dropped, reads return 0.
- wr_drop  output  1  registered pulse: a write was discarded the previous cycle.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. Sampled only at rising edge of `clk`.
- States: IDLE, CLEAR. Clear index `idx` is ADDR_W bits wide.
- rst=1 at an edge:
  - state<=CLEAR, idx<=0, wr_drop<=0.
  - No array write that cycle.
  - Applies also mid-clear, restarting at idx 0.
- CLEAR (rst=0):
  - Each edge writes mem[idx]<=0 and idx<=idx+1.
  - When idx==DEPTH-1, that entry is zeroed and state<=IDLE.
  - Exactly DEPTH CLEAR cycles after rst falls.
- IDLE, clr_req=1: state<=CLEAR, idx<=0.
  - A write presented in that same cycle is still performed, then overwritten by the clear.
- clr_req while in CLEAR: ignored, no restart.
- busy = rst OR (state==CLEAR), combinational.
  - busy=1 for the rst cycle and all DEPTH clear cycles.
  - Falls in the first IDLE cycle.
- Write (IDLE, rst=0, we=1):
  - mem[waddr]<=wdata at the edge.
  - Discarded if waddr>=DEPTH, or if ZERO_REG=1 and waddr==0.
  - Discarded addresses do not set wr_drop.
- wr_drop:
  - Next edge sets wr_drop=1 iff we=1 while busy=1 (including the rst cycle, which takes priority and clears it).
  - Otherwise wr_drop<=0; reset value 0.
- Read n (rdata1 and rdata2 independently), priority top-down:
  1. busy=1 -> 0.
  2. raddr>=DEPTH -> 0.
  3. ZERO_REG=1 and raddr==0 -> 0.
  4. BYPASS=1 and we=1 and waddr==raddr and the write is not discarded -> wdata (same cycle).
  5. Otherwise mem[raddr].
- Reset values: rdata1=rdata2=0 and busy=1 while rst=1; wr_drop=0 after reset.
- Array contents before first clear completes are undefined; never observable (reads masked by busy).
- Both read ports may address the same entry; both return the same value.
- Latency: write visible on reads from the cycle after the edge, or the same cycle with BYPASS=1.

Test Plan:
1. Reset/clear timing:
   - Stimulus: rst=1 for 1 cycle, then 0; DEPTH=32.
   - Required: busy=1 for exactly 33 cycles (rst + 32 clear); every raddr reads 0 afterwards.
2. Write/read with bypass:
   - Stimulus: we=1, waddr=5, wdata=32'hDEADBEEF, raddr1=5.
   - Required: BYPASS=1 -> rdata1=DEADBEEF same cycle; BYPASS=0 -> 0 that cycle, DEADBEEF next cycle.
3. Zero register:
   - Stimulus: ZERO_REG=1, write 32'h1234 to addr 0, read addr 0 on both ports in the write cycle and the next.
   - Required: 0 on both ports, same cycle and next; wr_drop stays 0.
4. Write during clear:
   - Stimulus: while busy, we=1 waddr=7 wdata=32'hA5A5A5A5.
   - Required: wr_drop=1 the next cycle; after busy falls, raddr=7 reads 0.
5. clr_req mid-use and reset mid-clear:
   - Stimulus: fill regs 1..31 with their index; pulse clr_req; at clear cycle 10 assert rst.
   - Required: busy stays high, clear restarts; busy falls 33 cycles after rst; all entries read 0.
6. Out-of-range address:
   - Stimulus: DEPTH=16, ADDR_W=5; write 32'hFF to addr 20, read addr 20.
   - Required: rdata=0; entries 0..15 unchanged.
